// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the PC / fetch stage: state encoding, bus widths
// and the start-address legality check.
package pc_fetch_unit_pkg;

   localparam int INSTR_WIDTH = 32;
   localparam int ADDR_WIDTH  = 64;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      RUN   = 2'd1,
      HALT  = 2'd2,
      FAULT = 2'd3
   } state_t;

   // A fetch address is usable when word aligned and inside the populated window.
   function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] addr,
                                    input logic [ADDR_WIDTH-1:0] limit);
      return (addr[1:0] == 2'b00) && (addr < limit);
   endfunction

endpackage

// File: rtl/pc_fetch_unit_next_pc_calc.sv
// Successor-PC arithmetic: sequential PC+4 or PC-relative word-offset branch.
module next_pc_calc
   import pc_fetch_unit_pkg::*;
(
   input  logic [ADDR_WIDTH-1:0] pc,
   input  logic [ADDR_WIDTH-1:0] sign_ext_imm,
   input  logic                  branch,
   input  logic                  uncondbranch,
   input  logic                  zero,
   output logic [ADDR_WIDTH-1:0] next_pc,
   output logic                  taken
);

   assign taken   = uncondbranch | (branch & zero);
   // Offset is in words; the shift and add wrap modulo 2^64 by construction.
   assign next_pc = taken ? (pc + (sign_ext_imm << 2)) : (pc + 64'd4);

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch sequencer: LOAD/RUN/HALT/FAULT control, PC register
// and retired-instruction counter feeding the instruction memory address bus.
module pc_fetch_unit
   import pc_fetch_unit_pkg::*;
#(
   parameter logic [ADDR_WIDTH-1:0] MemLimit   = 64'h060,
   parameter int                    CountWidth = 32
)
(
   input  logic                  CLK,
   input  logic                  resetl,
   input  logic [ADDR_WIDTH-1:0] StartPC,
   input  logic                  Stall,
   input  logic                  HaltReq,
   input  logic                  Branch,
   input  logic                  Uncondbranch,
   input  logic                  Zero,
   input  logic [ADDR_WIDTH-1:0] SignExtImm,
   output logic [ADDR_WIDTH-1:0] CurrentPC,
   output logic                  FetchValid,
   output logic                  Halted,
   output logic                  Fault,
   output logic [CountWidth-1:0] RetiredCount
);

   state_t                  state_reg, state_next;
   logic [ADDR_WIDTH-1:0]   pc_reg, pc_next;
   logic [CountWidth-1:0]   count_reg, count_next;
   logic [ADDR_WIDTH-1:0]   succ_pc;
   // Taken is only of interest to decode-side tracing; the successor already reflects it.
   logic                    taken_unused;

   next_pc_calc u_next_pc_calc (
      .pc           (pc_reg),
      .sign_ext_imm (SignExtImm),
      .branch       (Branch),
      .uncondbranch (Uncondbranch),
      .zero         (Zero),
      .next_pc      (succ_pc),
      .taken        (taken_unused)
   );

   always_ff @(posedge CLK or negedge resetl) begin
      if (!resetl) begin
         state_reg <= LOAD;
         pc_reg    <= '0;
         count_reg <= '0;
      end else begin
         state_reg <= state_next;
         pc_reg    <= pc_next;
         count_reg <= count_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      pc_next    = pc_reg;
      count_next = count_reg;
      case (state_reg)
         LOAD: begin
            // The start address is latched even when illegal so it is visible in FAULT.
            pc_next    = StartPC;
            state_next = addr_ok(StartPC, MemLimit) ? RUN : FAULT;
         end
         RUN: begin
            if (HaltReq) begin
               state_next = HALT;
            end else if (!Stall) begin
               if (succ_pc >= MemLimit) begin
                  state_next = FAULT;
               end else begin
                  pc_next    = succ_pc;
                  count_next = count_reg + CountWidth'(1);
               end
            end
         end
         default: begin
            state_next = state_reg;
         end
      endcase
   end

   assign CurrentPC    = pc_reg;
   assign RetiredCount = count_reg;
   assign FetchValid   = (state_reg == RUN);
   assign Halted       = (state_reg == HALT);
   assign Fault        = (state_reg == FAULT);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed vector bench for pc_fetch_unit, plus hand sequences for the
// narrow-window fault and asynchronous mid-run reset.
module tb_pc_fetch_unit;
   import pc_fetch_unit_pkg::*;

   logic                  CLK;
   logic                  resetl;
   logic [ADDR_WIDTH-1:0] StartPC;
   logic                  Stall, HaltReq, Branch, Uncondbranch, Zero;
   logic [ADDR_WIDTH-1:0] SignExtImm;

   logic [ADDR_WIDTH-1:0] CurrentPC, CurrentPC2;
   logic                  FetchValid, Halted, Fault;
   logic                  FetchValid2, Halted2, Fault2;
   logic [31:0]           RetiredCount, RetiredCount2;

   int n_vec = 0;
   int n_err = 0;

   pc_fetch_unit dut (
      .CLK          (CLK),
      .resetl       (resetl),
      .StartPC      (StartPC),
      .Stall        (Stall),
      .HaltReq      (HaltReq),
      .Branch       (Branch),
      .Uncondbranch (Uncondbranch),
      .Zero         (Zero),
      .SignExtImm   (SignExtImm),
      .CurrentPC    (CurrentPC),
      .FetchValid   (FetchValid),
      .Halted       (Halted),
      .Fault        (Fault),
      .RetiredCount (RetiredCount)
   );

   // Narrow-window instance for the fault-at-limit case.
   pc_fetch_unit #(.MemLimit(64'h05C), .CountWidth(32)) dut2 (
      .CLK          (CLK),
      .resetl       (resetl),
      .StartPC      (StartPC),
      .Stall        (Stall),
      .HaltReq      (HaltReq),
      .Branch       (Branch),
      .Uncondbranch (Uncondbranch),
      .Zero         (Zero),
      .SignExtImm   (SignExtImm),
      .CurrentPC    (CurrentPC2),
      .FetchValid   (FetchValid2),
      .Halted       (Halted2),
      .Fault        (Fault2),
      .RetiredCount (RetiredCount2)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      string       name;
      logic        rst;
      logic [63:0] start;
      logic        stall, halt, br, ub, z;
      logic [63:0] imm;
      logic [63:0] pc;
      logic        valid, hlt, flt;
      logic [31:0] cnt;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input string name, input logic rst, input logic [63:0] start,
                      input logic stall, input logic halt, input logic br,
                      input logic ub, input logic z, input logic [63:0] imm,
                      input logic [63:0] pc, input logic valid, input logic hlt,
                      input logic flt, input logic [31:0] cnt);
      vec_t v;
      v.name = name; v.rst = rst; v.start = start;
      v.stall = stall; v.halt = halt; v.br = br; v.ub = ub; v.z = z; v.imm = imm;
      v.pc = pc; v.valid = valid; v.hlt = hlt; v.flt = flt; v.cnt = cnt;
      tbl.push_back(v);
   endtask

   task automatic check(input string name, input logic [63:0] pc, input logic valid,
                        input logic hlt, input logic flt, input logic [31:0] cnt);
      n_vec++;
      if (CurrentPC !== pc || FetchValid !== valid || Halted !== hlt ||
          Fault !== flt || RetiredCount !== cnt) begin
         n_err++;
         $display("FAIL %s: got pc=%h v=%b h=%b f=%b cnt=%0d, expected pc=%h v=%b h=%b f=%b cnt=%0d",
                  name, CurrentPC, FetchValid, Halted, Fault, RetiredCount,
                  pc, valid, hlt, flt, cnt);
      end else begin
         $display("ok   %s: pc=%h v=%b h=%b f=%b cnt=%0d",
                  name, CurrentPC, FetchValid, Halted, Fault, RetiredCount);
      end
   endtask

   task automatic check2(input string name, input logic [63:0] pc, input logic valid,
                         input logic flt, input logic [31:0] cnt);
      n_vec++;
      if (CurrentPC2 !== pc || FetchValid2 !== valid || Halted2 !== 1'b0 ||
          Fault2 !== flt || RetiredCount2 !== cnt) begin
         n_err++;
         $display("FAIL %s: got pc=%h v=%b h=%b f=%b cnt=%0d, expected pc=%h v=%b h=0 f=%b cnt=%0d",
                  name, CurrentPC2, FetchValid2, Halted2, Fault2, RetiredCount2,
                  pc, valid, flt, cnt);
      end else begin
         $display("ok   %s: pc=%h v=%b f=%b cnt=%0d",
                  name, CurrentPC2, FetchValid2, Fault2, RetiredCount2);
      end
   endtask

   // Called just after a rising edge; the release lands well before the next one.
   task automatic do_reset(input logic [63:0] start);
      resetl = 1'b0;
      StartPC = start;
      {Stall, HaltReq, Branch, Uncondbranch, Zero} = 5'b0;
      SignExtImm = '0;
      #2;
      check("in_reset", 64'h0, 1'b0, 1'b0, 1'b0, 32'd0);
      #1 resetl = 1'b1;
   endtask

   task automatic edge_check(input string name, input logic [63:0] pc, input logic valid,
                             input logic hlt, input logic flt, input logic [31:0] cnt);
      @(posedge CLK);
      #1;
      check(name, pc, valid, hlt, flt, cnt);
   endtask

   localparam logic [63:0] M3 = 64'hFFFF_FFFF_FFFF_FFFD;
   localparam logic [63:0] M2 = 64'hFFFF_FFFF_FFFF_FFFE;

   initial begin
      resetl = 1'b0;
      StartPC = '0;
      {Stall, HaltReq, Branch, Uncondbranch, Zero} = 5'b0;
      SignExtImm = '0;

      //   name          rst start   st hl br ub z  imm     pc        v  h  f  cnt
      add("load0",       1, 64'h00, 0, 0, 0, 0, 0, 64'd0, 64'h00,  1, 0, 0, 0);
      add("seq4",        0, 64'h00, 0, 0, 0, 0, 0, 64'd0, 64'h04,  1, 0, 0, 1);
      add("seq8",        0, 64'h00, 0, 0, 0, 0, 0, 64'd0, 64'h08,  1, 0, 0, 2);
      add("seqC",        0, 64'h00, 0, 0, 0, 0, 0, 64'd0, 64'h0C,  1, 0, 0, 3);
      add("seq10",       0, 64'h00, 0, 0, 0, 0, 0, 64'd0, 64'h10,  1, 0, 0, 4);
      add("stall1",      0, 64'h00, 1, 0, 1, 1, 1, 64'd5, 64'h10,  1, 0, 0, 4);
      add("stall2",      0, 64'h00, 1, 0, 0, 0, 0, 64'd0, 64'h10,  1, 0, 0, 4);
      add("stall3",      0, 64'h00, 1, 0, 0, 0, 0, 64'd0, 64'h10,  1, 0, 0, 4);
      add("unstall",     0, 64'h00, 0, 0, 0, 0, 0, 64'd0, 64'h14,  1, 0, 0, 5);
      add("halt_stall",  0, 64'h00, 1, 1, 0, 1, 0, 64'd1, 64'h14,  0, 1, 0, 5);
      for (int i = 0; i < 5; i++)
         add("halt_frz",  0, 64'h00, 0, 0, 1, 1, 1, 64'd2, 64'h14,  0, 1, 0, 5);
      add("load28",      1, 64'h28, 0, 0, 0, 0, 0, 64'd0, 64'h28,  1, 0, 0, 0);
      add("b_back",      0, 64'h28, 0, 0, 0, 1, 0, M3,    64'h1C,  1, 0, 0, 1);
      add("cbz_taken",   0, 64'h28, 0, 0, 1, 0, 1, 64'd4, 64'h2C,  1, 0, 0, 2);
      add("load1C",      1, 64'h1C, 0, 0, 0, 0, 0, 64'd0, 64'h1C,  1, 0, 0, 0);
      add("cbz_nt",      0, 64'h1C, 0, 0, 1, 0, 0, 64'd4, 64'h20,  1, 0, 0, 1);
      add("br_and_b",    0, 64'h1C, 0, 0, 1, 1, 0, 64'd1, 64'h24,  1, 0, 0, 2);
      add("load_misal",  1, 64'h02, 0, 0, 0, 0, 0, 64'd0, 64'h02,  0, 0, 1, 0);
      add("fault_frz",   0, 64'h02, 0, 0, 0, 1, 0, 64'd1, 64'h02,  0, 0, 1, 0);
      add("load_limit",  1, 64'h60, 0, 0, 0, 0, 0, 64'd0, 64'h60,  0, 0, 1, 0);
      add("load5C",      1, 64'h5C, 0, 0, 0, 0, 0, 64'd0, 64'h5C,  1, 0, 0, 0);
      add("adv_limit",   0, 64'h5C, 0, 0, 0, 0, 0, 64'd0, 64'h5C,  0, 0, 1, 0);
      add("load04",      1, 64'h04, 0, 0, 0, 0, 0, 64'd0, 64'h04,  1, 0, 0, 0);
      add("wrap_neg",    0, 64'h04, 0, 0, 0, 1, 0, M2,    64'h04,  0, 0, 1, 0);

      @(posedge CLK);
      #1;
      foreach (tbl[i]) begin
         if (tbl[i].rst) do_reset(tbl[i].start);
         Stall        = tbl[i].stall;
         HaltReq      = tbl[i].halt;
         Branch       = tbl[i].br;
         Uncondbranch = tbl[i].ub;
         Zero         = tbl[i].z;
         SignExtImm   = tbl[i].imm;
         edge_check(tbl[i].name, tbl[i].pc, tbl[i].valid, tbl[i].hlt, tbl[i].flt, tbl[i].cnt);
      end

      // Narrow window: 0x58 is legal, its successor 0x5C is the limit.
      do_reset(64'h58);
      @(posedge CLK);
      #1;
      check2("w2_load58", 64'h58, 1'b1, 1'b0, 32'd0);
      @(posedge CLK);
      #1;
      check2("w2_adv_fault", 64'h58, 1'b0, 1'b1, 32'd0);
      check("w1_adv5C", 64'h5C, 1'b1, 1'b0, 1'b0, 32'd1);

      // Asynchronous reset between edges while running at 0x40.
      do_reset(64'h38);
      edge_check("ar_load38", 64'h38, 1'b1, 1'b0, 1'b0, 32'd0);
      edge_check("ar_3C",     64'h3C, 1'b1, 1'b0, 1'b0, 32'd1);
      edge_check("ar_40",     64'h40, 1'b1, 1'b0, 1'b0, 32'd2);
      #3 resetl = 1'b0;
      #1;
      check("ar_async", 64'h0, 1'b0, 1'b0, 1'b0, 32'd0);
      StartPC = 64'h34;
      #1 resetl = 1'b1;
      edge_check("ar_load34", 64'h34, 1'b1, 1'b0, 1'b0, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter and next-PC stage directly upstream of the instruction memory; drives its 64-bit Address bus and sequences the fetch stream for the single-cycle LEGv8 datapath.
- Holds PC, computes sequential/branch successor, supports stall and halt, and faults on misaligned start or fetch beyond the populated memory window.
- Keeps a retired-instruction counter for bench checking.

Parameters:
- MemLimit, 64'h060, first byte address past populated instruction memory; fetching at or above it is a fault.
- CountWidth, 32, width of retired-instruction counter.

Ports:
- CLK  in  1  clock, rising edge
- resetl  in  1  asynchronous active-low reset
- StartPC  in  64  PC loaded on first clock after reset release
- Stall  in  1  hold PC this cycle
- HaltReq  in  1  stop fetching (sticky until reset)
- Branch  in  1  CBZ-class conditional branch decoded
- Uncondbranch  in  1  B decoded
- Zero  in  1  ALU zero flag for current instruction
- SignExtImm  in  64  sign-extended word offset from decode
- CurrentPC  out  64  fetch address to instruction memory
- FetchValid  out  1  high in RUN state; CurrentPC is a live fetch
- Halted  out  1  high in HALT state
- Fault  out  1  high in FAULT state
- RetiredCount  out  CountWidth  number of PC advances since reset

Behaviour:
- Reset (resetl=0, async): CurrentPC=0, state=LOAD, FetchValid=0, Halted=0, Fault=0, RetiredCount=0.
- States: LOAD, RUN, HALT, FAULT.
- LOAD, first rising edge after release: if StartPC[1:0]!=0 or StartPC>=MemLimit, go to FAULT with PC=StartPC. Otherwise PC<=StartPC and go to RUN. LOAD ignores Stall and HaltReq.
- RUN, per edge, in priority order:
  - HaltReq=1: go to HALT and hold PC.
  - else Stall=1: hold PC and count.
  - else advance.
- Advance:
  - Taken = Uncondbranch | (Branch & Zero).
  - NextPC = Taken ? PC + (SignExtImm<<2) : PC + 4. Arithmetic is 64-bit, modulo 2^64, and wraps silently.
  - If NextPC >= MemLimit (unsigned): go to FAULT, hold PC, do not increment the count.
  - Otherwise PC<=NextPC and RetiredCount+=1. RetiredCount wraps at 2^CountWidth.
- HALT and FAULT are terminal until resetl=0. PC and RetiredCount are frozen in both.
- Outputs: FetchValid=(state==RUN), Halted=(state==HALT), Fault=(state==FAULT). All outputs are registered or decoded from state only; none is combinational from inputs.
- Latency: NextPC appears on CurrentPC one edge after the inputs that select it are sampled. Instruction memory then returns data combinationally.
- Simultaneous events: HaltReq and Stall together means HALT. Branch and Uncondbranch together means taken. Branch=1 with Zero=0 gives PC+4.
- Reset asserted mid-run: immediate return to the reset values, regardless of state.

Decomposition:
- Shared package: state encoding constants (LOAD=2'd0, RUN=2'd1, HALT=2'd2, FAULT=2'd3) and the instruction width and address width constants (32, 64). Decode and the bench import them.
- One sub-module: next_pc_calc, purely combinational. It takes PC, SignExtImm, Branch, Uncondbranch and Zero, and produces NextPC and Taken. The FSM, PC register and counter stay in pc_fetch_unit.

Test Plan:
- Reset, StartPC=0, no branches for 4 edges -> CurrentPC 0 (LOAD edge), then 4, 8, 0xC; RetiredCount=3; FetchValid=1.
- PC=0x28, Uncondbranch=1, SignExtImm=-3 (64'hFFFF_FFFF_FFFF_FFFD) -> next CurrentPC=0x1C. PC=0x1C, Branch=1, Zero=1, SignExtImm=4 -> 0x2C. Same with Zero=0 -> 0x20.
- Stall held 3 edges at PC=0x10 -> PC stays 0x10 and RetiredCount unchanged; on release -> 0x14.
- HaltReq=1 with Stall=1 at PC=0x14 -> Halted=1, FetchValid=0, PC frozen at 0x14 for 5 further edges despite branch inputs.
- StartPC=0x02 -> Fault=1 after LOAD edge. StartPC=0x58 with MemLimit=0x5C: advance to 0x5C -> Fault=1, PC held 0x58, count unchanged.
- Pull resetl low between edges while in RUN at PC=0x40 -> CurrentPC=0 and RetiredCount=0 immediately, without waiting for a clock edge; after release with StartPC=0x34 -> PC=0x34.
